// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Startup and lock-maintenance controller for the PLL macro. It powers the
//   PLL up with the loop open so the VCO can settle, then closes the loop and
//   waits for a run of synchronized lock samples. If acquisition times out,
//   it steps the VCO cap bank and retries until cap_max is exhausted. Once
//   locked, it watches for a sustained loss of lock and re-runs the
//   calibration at the same cap setting.
//
// Ports
//   clk_160MHz      : block clock
//   rst_b           : asynchronous active-low reset
//   enable          : run request; low forces IDLE on the next edge
//   instlock_async  : PLL instantaneous-lock flag (asynchronous)
//   cap_start       : first cap setting tried
//   cap_max         : last cap setting tried
//   pll_enable      : PLL enable
//   connect_pll     : closes the PLL loop
//   vco_cap_select  : VCO cap bank select
//   pll_locked      : lock declared
//   lock_fail       : all cap settings exhausted
//   state           : FSM state code
//   relock_count    : loss-of-lock events, saturating at 255
module pll_lock_sequencer #(
  parameter int WAIT_CYCLES  = 64,
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4,
  parameter int TIMEOUT      = 4096,
  parameter int CAP_W        = 9
) (
  input  logic             clk_160MHz,
  input  logic             rst_b,
  input  logic             enable,
  input  logic             instlock_async,
  input  logic [CAP_W-1:0] cap_start,
  input  logic [CAP_W-1:0] cap_max,
  output logic             pll_enable,
  output logic             connect_pll,
  output logic [CAP_W-1:0] vco_cap_select,
  output logic             pll_locked,
  output logic             lock_fail,
  output logic [2:0]       state,
  output logic [7:0]       relock_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAL     = 3'd1;
  localparam logic [2:0] S_ACQUIRE = 3'd2;
  localparam logic [2:0] S_LOCKED  = 3'd3;
  localparam logic [2:0] S_FAIL    = 3'd4;

  // One cycle counter serves the CAL wait and the ACQUIRE timeout; one run
  // counter serves the lock run (ACQUIRE) and the unlock run (LOCKED). Both
  // clear on every state change, so sharing them is safe.
  localparam int CYC_MAX = (WAIT_CYCLES > TIMEOUT) ? WAIT_CYCLES : TIMEOUT;
  localparam int RUN_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int RUN_W   = $clog2(RUN_MAX + 1);

  logic [1:0]       sync_reg;
  logic             lk;
  logic [2:0]       state_reg, state_next;
  logic [CAP_W-1:0] cap_reg, cap_next;
  logic [7:0]       relock_reg, relock_next;
  logic [CYC_W-1:0] cyc_reg, cyc_next;
  logic [RUN_W-1:0] run_reg, run_next;

  assign lk = sync_reg[1];

  always_comb begin
    state_next  = state_reg;
    cap_next    = cap_reg;
    relock_next = relock_reg;
    cyc_next    = '0;
    run_next    = run_reg;

    case (state_reg)
      S_IDLE: begin
        if (enable) begin
          state_next  = S_CAL;
          cap_next    = cap_start;
          relock_next = 8'd0;
        end
      end
      S_CAL: begin
        cyc_next = cyc_reg + 1'b1;
        if (cyc_reg == CYC_W'(WAIT_CYCLES - 1)) begin
          state_next = S_ACQUIRE;
        end
      end
      S_ACQUIRE: begin
        cyc_next = cyc_reg + 1'b1;
        run_next = lk ? run_reg + 1'b1 : '0;
        // Lock is tested first so it wins over a coincident timeout.
        if (lk && (run_reg == RUN_W'(LOCK_COUNT - 1))) begin
          state_next = S_LOCKED;
        end else if (cyc_reg == CYC_W'(TIMEOUT - 1)) begin
          if (cap_reg < cap_max) begin
            cap_next   = cap_reg + 1'b1;
            state_next = S_CAL;
          end else begin
            state_next = S_FAIL;
          end
        end
      end
      S_LOCKED: begin
        if (lk) begin
          run_next = '0;
        end else if (run_reg == RUN_W'(UNLOCK_COUNT - 1)) begin
          state_next  = S_CAL;
          relock_next = (relock_reg == 8'hFF) ? relock_reg : relock_reg + 8'd1;
        end else begin
          run_next = run_reg + 1'b1;
        end
      end
      S_FAIL: begin
        state_next = S_FAIL;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Dropping enable overrides every other transition; IDLE keeps the cap.
    if (!enable) begin
      state_next  = S_IDLE;
      cap_next    = cap_reg;
      relock_next = relock_reg;
    end

    if (state_next != state_reg) begin
      cyc_next = '0;
      run_next = '0;
    end
  end

  // Outputs are decoded from the next state so they are registered and
  // line up with the state register.
  always_ff @(posedge clk_160MHz or negedge rst_b) begin
    if (!rst_b) begin
      sync_reg    <= 2'b00;
      state_reg   <= S_IDLE;
      cap_reg     <= '0;
      relock_reg  <= 8'd0;
      cyc_reg     <= '0;
      run_reg     <= '0;
      pll_enable  <= 1'b0;
      connect_pll <= 1'b0;
      pll_locked  <= 1'b0;
      lock_fail   <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[0], instlock_async};
      state_reg   <= state_next;
      cap_reg     <= cap_next;
      relock_reg  <= relock_next;
      cyc_reg     <= cyc_next;
      run_reg     <= run_next;
      pll_enable  <= (state_next == S_CAL) || (state_next == S_ACQUIRE) ||
                     (state_next == S_LOCKED);
      connect_pll <= (state_next == S_ACQUIRE) || (state_next == S_LOCKED);
      pll_locked  <= (state_next == S_LOCKED);
      lock_fail   <= (state_next == S_FAIL);
    end
  end

  assign state          = state_reg;
  assign vco_cap_select = cap_reg;
  assign relock_count   = relock_reg;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer
//   Scoreboard bench. Each scenario computes its expected output events
//   (edge number, state, cap, relock count) from the sequencing rules with
//   plain arithmetic and queues them; an independent monitor pops and
//   compares whenever the DUT's output vector changes.
module tb_pll_lock_sequencer;

  localparam int WAIT  = 64;
  localparam int LOCKC = 16;
  localparam int TMO   = 4096;

  logic       clk_160MHz = 1'b0;
  logic       rst_b;
  logic       enable;
  logic       instlock_async;
  logic [8:0] cap_start, cap_max;
  logic       pll_enable, connect_pll, pll_locked, lock_fail;
  logic [8:0] vco_cap_select;
  logic [2:0] state;
  logic [7:0] relock_count;

  typedef struct {
    int         edge_no;
    logic [2:0] st;
    logic [8:0] cap;
    logic [7:0] rl;
  } ev_t;

  ev_t        exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         edge_cnt = 0;
  int         last_edge = 0;
  int         m_cap = 0;
  int         m_relock = 0;
  bit         m_locked = 0;
  logic [8:0] g_cap;
  logic       g_valid, force_low, toggle_en;
  logic       tgl = 1'b0;
  logic [23:0] dut_vec, prev_vec;
  bit         mon_en = 0;

  pll_lock_sequencer dut (
    .clk_160MHz    (clk_160MHz),
    .rst_b         (rst_b),
    .enable        (enable),
    .instlock_async(instlock_async),
    .cap_start     (cap_start),
    .cap_max       (cap_max),
    .pll_enable    (pll_enable),
    .connect_pll   (connect_pll),
    .vco_cap_select(vco_cap_select),
    .pll_locked    (pll_locked),
    .lock_fail     (lock_fail),
    .state         (state),
    .relock_count  (relock_count)
  );

  always #3 clk_160MHz = ~clk_160MHz;
  always @(posedge clk_160MHz) edge_cnt <= edge_cnt + 1;
  always @(negedge clk_160MHz) tgl <= ~tgl;

  // PLL stand-in: locks only at the "good" cap, unless forced low; in toggle
  // mode it chatters at any other cap.
  assign instlock_async = (g_valid && (vco_cap_select == g_cap)) ? ~force_low
                                                                  : (toggle_en & tgl);

  assign dut_vec = {state, pll_enable, connect_pll, pll_locked, lock_fail,
                    vco_cap_select, relock_count};

  function automatic logic [23:0] pack_exp(logic [2:0] st, logic [8:0] cap, logic [7:0] rl);
    logic pe, cp, lkd, lf;
    pe  = (st == 3'd1) || (st == 3'd2) || (st == 3'd3);
    cp  = (st == 3'd2) || (st == 3'd3);
    lkd = (st == 3'd3);
    lf  = (st == 3'd4);
    return {st, pe, cp, lkd, lf, cap, rl};
  endfunction

  task automatic push(int e, logic [2:0] st, int cap, int rl);
    ev_t ev;
    ev.edge_no = e;
    ev.st      = st;
    ev.cap     = 9'(cap);
    ev.rl      = 8'(rl);
    exp_q.push_back(ev);
    if (e > last_edge) last_edge = e;
  endtask

  always @(negedge clk_160MHz) begin : monitor
    logic [23:0] cur;
    ev_t         ev;
    cur = dut_vec;
    if (mon_en && (cur !== prev_vec)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event edge=%0d got=%h", edge_cnt, cur);
      end else begin
        ev = exp_q.pop_front();
        total += 2;
        if (cur !== pack_exp(ev.st, ev.cap, ev.rl)) begin
          bad++;
          $display("FAIL event_outputs edge=%0d got=%h want=%h", edge_cnt, cur,
                   pack_exp(ev.st, ev.cap, ev.rl));
        end
        if (edge_cnt != ev.edge_no) begin
          bad++;
          $display("FAIL event_edge state=%0d got=%0d want=%0d", ev.st, edge_cnt, ev.edge_no);
        end else begin
          $display("event edge=%0d state=%0d cap=%0d relock=%0d", edge_cnt, state,
                   vco_cap_select, relock_count);
        end
      end
    end
    prev_vec = cur;
  end

  task automatic drain();
    while (exp_q.size() > 0 && edge_cnt <= last_edge + 8) begin
      @(negedge clk_160MHz);
      #1;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d got_now=%0d want_edge=%0d", exp_q.size(), edge_cnt,
               exp_q[0].edge_no);
      exp_q.delete();
    end
  endtask

  // Start a run and predict the whole acquisition: each cap spends WAIT
  // cycles in CAL, then either locks LOCKC samples later or times out after
  // TMO cycles and moves to the next cap (or FAIL after cap_max).
  task automatic run_acq(int s, int m, int g, bit gv, bit tg);
    int c, t, acq;
    @(negedge clk_160MHz);
    cap_start = 9'(s);
    cap_max   = 9'(m);
    g_cap     = 9'(g);
    g_valid   = gv;
    toggle_en = tg;
    enable    = 1'b1;
    t = edge_cnt + 1;
    c = s;
    m_relock = 0;
    m_locked = 0;
    push(t, 3'd1, c, 0);
    for (int k = 0; k < 600; k++) begin
      acq = t + WAIT;
      push(acq, 3'd2, c, 0);
      if (gv && c == g) begin
        push(acq + LOCKC, 3'd3, c, 0);
        m_locked = 1;
        break;
      end
      t = acq + TMO;
      if (c < m) begin
        c++;
        push(t, 3'd1, c, 0);
      end else begin
        push(t, 3'd4, c, 0);
        break;
      end
    end
    m_cap = c;
    $display("run start=%0d max=%0d good=%0d/%0d toggle=%0d", s, m, g, gv, tg);
    drain();
  endtask

  task automatic stop_run();
    @(negedge clk_160MHz);
    enable = 1'b0;
    push(edge_cnt + 1, 3'd0, m_cap, m_relock);
    drain();
    g_valid   = 1'b0;
    toggle_en = 1'b0;
  endtask

  // Low pulse of len cycles on instlock while LOCKED. The 4th consecutive
  // synchronized low sample lands on edge p+5 (two-flop delay + 4 samples).
  task automatic glitch(int len);
    int p;
    @(negedge clk_160MHz);
    p = edge_cnt + 1;
    if (len >= 4) begin
      m_relock = (m_relock < 255) ? m_relock + 1 : 255;
      push(p + 5, 3'd1, m_cap, m_relock);
      push(p + 5 + WAIT, 3'd2, m_cap, m_relock);
      push(p + 5 + WAIT + LOCKC, 3'd3, m_cap, m_relock);
    end
    force_low = 1'b1;
    repeat (len) @(posedge clk_160MHz);
    @(negedge clk_160MHz);
    force_low = 1'b0;
    if (len >= 4) begin
      drain();
    end else begin
      repeat (12) @(negedge clk_160MHz);
      total++;
      if (pll_locked !== 1'b1) begin
        bad++;
        $display("FAIL short_glitch len=%0d pll_locked got=%b want=1", len, pll_locked);
      end
    end
    $display("glitch len=%0d relock=%0d", len, relock_count);
  endtask

  task automatic reset_mid();
    @(negedge clk_160MHz);
    #1;
    push(edge_cnt + 1, 3'd0, 0, 0);
    rst_b = 1'b0;
    #1;
    total++;
    if (dut_vec !== 24'h0) begin
      bad++;
      $display("FAIL async_reset got=%h want=000000", dut_vec);
    end
    enable   = 1'b0;
    m_relock = 0;
    m_cap    = 0;
    repeat (3) @(negedge clk_160MHz);
    rst_b = 1'b1;
    drain();
    $display("reset mid-run state=%0d", state);
  endtask

  initial begin
    #(6 * 120000);
    bad++;
    $display("FAIL watchdog edge=%0d", edge_cnt);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, m, g, r;
    rst_b     = 1'b1;
    enable    = 1'b0;
    cap_start = '0;
    cap_max   = '0;
    g_cap     = '0;
    g_valid   = 1'b0;
    force_low = 1'b0;
    toggle_en = 1'b0;
    #1 rst_b = 1'b0;
    #1;
    total++;
    if (dut_vec !== 24'h0) begin
      bad++;
      $display("FAIL reset_state got=%h want=000000", dut_vec);
    end
    repeat (3) @(negedge clk_160MHz);
    rst_b = 1'b1;
    repeat (5) @(negedge clk_160MHz);
    total++;
    if (dut_vec !== 24'h0) begin
      bad++;
      $display("FAIL idle_after_reset got=%h want=000000", dut_vec);
    end
    mon_en = 1;

    // Lock at the first cap, short and long glitches, then reset in LOCKED.
    run_acq(10, 20, 10, 1, 0);
    glitch(3);
    glitch(4);
    reset_mid();

    // Two timeouts before locking at cap 12.
    run_acq(10, 20, 12, 1, 0);
    stop_run();

    // Single cap, never locks: FAIL, then enable low clears it.
    run_acq(5, 5, 0, 0, 0);
    stop_run();

    // Chattering lock flag never builds a run; next cap locks.
    run_acq(30, 31, 31, 1, 1);
    stop_run();

    // Randomized cap ranges and lock points.
    for (int i = 0; i < 3; i++) begin
      s = int'($urandom_range(0, 511));
      r = int'($urandom_range(0, 2));
      if (r == 0) m = s;
      else if (r == 1) m = (s < 511) ? s + 1 : 511;
      else m = (s > 0) ? int'($urandom_range(0, s - 1)) : 0;
      g = s + int'($urandom_range(0, 2));
      run_acq(s, m, g, (g <= 511), 0);
      if (m_locked) begin
        glitch(int'($urandom_range(1, 6)));
        glitch(int'($urandom_range(1, 6)));
      end
      stop_run();
    end

    // Relock counter saturation, then a fresh enable clears it.
    run_acq(100, 100, 100, 1, 0);
    for (int i = 0; i < 256; i++) glitch(4);
    stop_run();
    run_acq(100, 100, 100, 1, 0);
    stop_run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
